// File: rtl/hourly_strike_generator_if.sv
// Bundle of controls, BCD time digits and chime outputs between the time chain and buzzer driver.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or one-cycle strobe.
interface hourly_strike_generator_if;
    logic       EN_work;
    logic       tick_1hz;
    logic       test_strike;
    logic [3:0] sec_low;
    logic [3:0] sec_high;
    logic [3:0] min_low;
    logic [3:0] min_high;
    logic [3:0] hour_low;
    logic [3:0] hour_high;
    logic       Chime;
    logic       Chime_tone;
    logic       busy;
    logic [3:0] strikes_left;

    modport master (
        output EN_work, tick_1hz, test_strike,
        output sec_low, sec_high, min_low, min_high, hour_low, hour_high,
        input  Chime, Chime_tone, busy, strikes_left
    );

    modport slave (
        input  EN_work, tick_1hz, test_strike,
        input  sec_low, sec_high, min_low, min_high, hour_low, hour_high,
        output Chime, Chime_tone, busy, strikes_left
    );
endinterface

// File: rtl/hourly_strike_generator.sv
// Emits a train of N timed strike pulses (with gated tone) at hh:00:00 or on a manual test strike.
// Latency: Chime rises the cycle after the trigger edge; all outputs are registered.
// No backpressure: triggers arriving while a train runs are dropped; EN_work=1 aborts at the next edge.
module hourly_strike_generator #(
    parameter int MODE        = 1,
    parameter int FIXED_COUNT = 3,
    parameter int ON_CYCLES   = 4,
    parameter int OFF_CYCLES  = 3,
    parameter int TONE_HALF   = 1,
    parameter int CNT_W       = 16
) (
    input  logic CLK,
    input  logic RST,
    hourly_strike_generator_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [3:0]       FIXED_N   = 4'(FIXED_COUNT);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [3:0]       left_q, left_d;
    logic             tone_q, tone_d;
    logic             chime_q, busy_q;

    logic [7:0] hour_val;
    logic       hour_ok;
    logic       at_top;
    logic [3:0] hour_mod;
    logic [3:0] hour12;
    logic [3:0] strike_n;
    logic       time_trig;
    logic       man_trig;

    // Decode the BCD hour into a 12-hour strike count; invalid digits fall back to the fixed count.
    always_comb begin
        hour_val  = {4'd0, bus.hour_high} * 8'd10 + {4'd0, bus.hour_low};
        hour_ok   = (bus.hour_low <= 4'd9) && (bus.hour_high <= 4'd2) && (hour_val <= 8'd23);
        at_top    = (bus.sec_low == 4'd0) && (bus.sec_high == 4'd0) &&
                    (bus.min_low == 4'd0) && (bus.min_high == 4'd0);
        // For 12..23 the low nibble minus 12 (mod 16) equals hour-12, which always fits in 4 bits.
        hour_mod  = (hour_val >= 8'd12) ? (hour_val[3:0] - 4'd12) : hour_val[3:0];
        hour12    = (hour_mod == 4'd0) ? 4'd12 : hour_mod;
        strike_n  = ((MODE == 1) && hour_ok) ? hour12 : FIXED_N;
        time_trig = bus.tick_1hz && !bus.EN_work && at_top && hour_ok;
        man_trig  = bus.test_strike && !bus.EN_work;
    end

    // Next-state logic: strike/gap phase timing, strike countdown and tone toggling.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tone_cnt_d = tone_cnt_q;
        left_d     = left_q;
        tone_d     = 1'b0;
        if (bus.EN_work) begin
            state_d    = ST_IDLE;
            phase_d    = '0;
            tone_cnt_d = '0;
            left_d     = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (time_trig || man_trig) begin
                        state_d    = ST_ON;
                        phase_d    = '0;
                        tone_cnt_d = '0;
                        left_d     = strike_n;
                        tone_d     = 1'b1;
                    end
                end
                ST_ON: begin
                    if (phase_q == ON_LAST) begin
                        phase_d    = '0;
                        tone_cnt_d = '0;
                        left_d     = left_q - 4'd1;
                        state_d    = (left_q == 4'd1) ? ST_IDLE : ST_OFF;
                    end else begin
                        phase_d = phase_q + CNT_ONE;
                        if (tone_cnt_q == TONE_LAST) begin
                            tone_cnt_d = '0;
                            tone_d     = ~tone_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + CNT_ONE;
                            tone_d     = tone_q;
                        end
                    end
                end
                ST_OFF: begin
                    if (phase_q == OFF_LAST) begin
                        state_d    = ST_ON;
                        phase_d    = '0;
                        tone_cnt_d = '0;
                        tone_d     = 1'b1;
                    end else begin
                        phase_d = phase_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    phase_d    = '0;
                    tone_cnt_d = '0;
                    left_d     = 4'd0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            tone_cnt_q <= '0;
            left_q     <= 4'd0;
            tone_q     <= 1'b0;
            chime_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tone_cnt_q <= tone_cnt_d;
            left_q     <= left_d;
            tone_q     <= tone_d;
            chime_q    <= (state_d == ST_ON);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign bus.Chime        = chime_q;
    assign bus.Chime_tone   = tone_q;
    assign bus.busy         = busy_q;
    assign bus.strikes_left = left_q;

endmodule
